// File: rtl/sram_arb_pkg.sv
// Shared defaults and address-split helpers for banked_sram_arbiter.
package sram_arb_pkg;

    localparam int DEF_NUM_PORTS  = 3;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_NUM_BANKS  = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Low-order interleave: bank from the bottom bits, row from the rest.
    function automatic int bank_of(input logic [31:0] addr, input int bank_bits);
        return int'(addr & ((32'd1 << bank_bits) - 32'd1));
    endfunction

    function automatic int row_of(input logic [31:0] addr, input int bank_bits);
        return int'(addr >> bank_bits);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past each winner.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);
    localparam int PTR_W = clog2(NUM_PORTS);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;

    // Search upward from the pointer; the first requester found wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr_q) + k) % NUM_PORTS;
            if (!found && req_i[PTR_W'(idx)]) begin
                found               = 1'b1;
                gnt_o[PTR_W'(idx)]  = 1'b1;
                ptr_d               = PTR_W'((idx + 1) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/banked_sram_arbiter.sv
// Multi-port SRAM over NUM_BANKS interleaved single-port banks, one rr_arbiter per bank.
// Define SRAM_ARB_BYTE_WRITE_EN to add per-byte write enables (be_i).
module banked_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0]                we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
`ifdef SRAM_ARB_BYTE_WRITE_EN
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
`endif
    output logic [NUM_PORTS-1:0]                gnt_o,
    output logic [NUM_PORTS-1:0]                rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata_o
);
    localparam int BANK_BITS = clog2(NUM_BANKS);
    localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
    localparam int DEPTH     = 1 << ROW_W;
    localparam int PORT_W    = clog2(NUM_PORTS);
`ifdef SRAM_ARB_BYTE_WRITE_EN
    localparam int BE_W      = DATA_WIDTH / 8;
    logic [BE_W-1:0]       be_w       [NUM_PORTS];
`endif

    logic [BANK_BITS-1:0]  bank_sel   [NUM_PORTS];
    logic [ROW_W-1:0]      row_sel    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_w    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  bank_gnt   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [NUM_PORTS-1:0]  rvalid_d;
    logic [BANK_BITS-1:0]  rbank_q    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rhold_q    [NUM_PORTS];

    genvar gi;

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign bank_sel[gi] = BANK_BITS'(bank_of(32'(addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]), BANK_BITS));
        assign row_sel[gi]  = ROW_W'(row_of(32'(addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]), BANK_BITS));
        assign wdata_w[gi]  = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef SRAM_ARB_BYTE_WRITE_EN
        assign be_w[gi]     = be_i[gi*BE_W +: BE_W];
`endif
        // While rvalid is low the port keeps showing the last word it read.
        assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] =
            rvalid_q[gi] ? bank_rdata[rbank_q[gi]] : rhold_q[gi];
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_PORTS-1:0]  req_vec;
        logic                  hit;
        logic [PORT_W-1:0]     sel;
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        always_comb begin
            req_vec = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req_vec[p] = req_i[p] && (bank_sel[p] == BANK_BITS'(gi));
            end
        end

        rr_arbiter #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req_i (req_vec),
            .gnt_o (bank_gnt[gi])
        );

        always_comb begin
            hit = |bank_gnt[gi];
            sel = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[gi][p]) sel = PORT_W'(p);
            end
        end

        always_ff @(posedge clk) begin
            if (hit) begin
                if (we_i[sel]) begin
`ifdef SRAM_ARB_BYTE_WRITE_EN
                    for (int k = 0; k < BE_W; k++) begin
                        if (be_w[sel][k]) mem[row_sel[sel]][k*8 +: 8] <= wdata_w[sel][k*8 +: 8];
                    end
`else
                    mem[row_sel[sel]] <= wdata_w[sel];
`endif
                end else begin
                    rd_q <= mem[row_sel[sel]];
                end
            end
        end

        assign bank_rdata[gi] = rd_q;
    end

    // A port targets exactly one bank, so OR-ing bank grants never merges two winners.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    assign rvalid_d = req_i & gnt_o & ~we_i;
    assign rvalid_o = rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rbank_q[p] <= '0;
                rhold_q[p] <= '0;
            end
        end else begin
            rvalid_q <= rvalid_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rvalid_d[p]) rbank_q[p] <= bank_sel[p];
                if (rvalid_q[p]) rhold_q[p] <= bank_rdata[rbank_q[p]];
            end
        end
    end

endmodule

// File: tb/tb_banked_sram_arbiter.sv
// Self-checking bench for banked_sram_arbiter: directed scenarios plus a randomized model run.
module tb_banked_sram_arbiter;
    localparam int NP  = 3;
    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int NB  = 4;
    localparam int BEW = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NP-1:0]  req, we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
`ifdef SRAM_ARB_BYTE_WRITE_EN
    logic [NP*BEW-1:0] be;
`endif
    logic [NP-1:0]  gnt, rvalid;
    logic [NP*DW-1:0] rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    banked_sram_arbiter #(
        .NUM_PORTS (NP), .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_BANKS (NB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
`ifdef SRAM_ARB_BYTE_WRITE_EN
        .be_i     (be),
`endif
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = r;
        we[p]  = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic idle_all();
        req = '0; we = '0; addr = '0; wdata = '0;
`ifdef SRAM_ARB_BYTE_WRITE_EN
        be = '1;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd_of(input int p);
        return rdata[p*DW +: DW];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b000) begin
            tests_failed++; $display("FAIL reset_rvalid_in_reset: got %b expected 000", rvalid);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b000) begin
            tests_failed++; $display("FAIL reset_rvalid: got %b expected 000", rvalid);
        end
        tests_run++;
        if (rdata !== '0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        tests_run++;
        if (gnt !== 3'b000) begin
            tests_failed++; $display("FAIL reset_gnt_noreq: got %b expected 000", gnt);
        end
    endtask

    task automatic test_write_read();
        step(); idle_all();
        drive_port(0, 1'b1, 1'b1, 16'h0005, 32'hDEADBEEF);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b001) begin
            tests_failed++; $display("FAIL wr_gnt: got %b expected 001", gnt);
        end
        step();
        drive_port(0, 1'b1, 1'b0, 16'h0005, 32'h0);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b001 || rvalid !== 3'b000) begin
            tests_failed++; $display("FAIL rd_gnt: got gnt %b rvalid %b expected 001 000", gnt, rvalid);
        end
        step(); idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b001 || rd_of(0) !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL rd_data: got rvalid %b rdata %h expected 001 deadbeef", rvalid, rd_of(0));
        end
        step();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b000 || rd_of(0) !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL rd_hold: got rvalid %b rdata %h expected 000 deadbeef", rvalid, rd_of(0));
        end
    endtask

    task automatic test_contention();
        logic [NP-1:0] exp_g;
        logic [NP-1:0] exp_v;
        step(); idle_all();
        drive_port(0, 1'b1, 1'b0, 16'h0000, 32'h0);
        drive_port(1, 1'b1, 1'b0, 16'h0004, 32'h0);
        drive_port(2, 1'b1, 1'b0, 16'h0008, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_g = NP'(1 << (c % NP));
            tests_run++;
            if (gnt !== exp_g) begin
                tests_failed++; $display("FAIL contention_gnt[%0d]: got %b expected %b", c, gnt, exp_g);
            end
            if (c > 0) begin
                exp_v = NP'(1 << ((c - 1) % NP));
                tests_run++;
                if (rvalid !== exp_v) begin
                    tests_failed++; $display("FAIL contention_rvalid[%0d]: got %b expected %b", c, rvalid, exp_v);
                end
            end
            step();
        end
        idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b100) begin
            tests_failed++; $display("FAIL contention_last_rvalid: got %b expected 100", rvalid);
        end
    endtask

    task automatic test_parallel_banks();
        step(); idle_all();
        for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 1'b1, AW'(p + 1), 32'hA0000000 + DW'(p));
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b111) begin
            tests_failed++; $display("FAIL parallel_wr_gnt: got %b expected 111", gnt);
        end
        step();
        for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 1'b0, AW'(p + 1), 32'h0);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b111) begin
            tests_failed++; $display("FAIL parallel_rd_gnt: got %b expected 111", gnt);
        end
        step(); idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b111) begin
            tests_failed++; $display("FAIL parallel_rvalid: got %b expected 111", rvalid);
        end
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (rd_of(p) !== 32'hA0000000 + DW'(p)) begin
                tests_failed++; $display("FAIL parallel_rdata[%0d]: got %h expected %h", p, rd_of(p), 32'hA0000000 + DW'(p));
            end
        end
    endtask

    task automatic test_extremes();
        step(); idle_all();
        drive_port(2, 1'b1, 1'b1, 16'hFFFF, 32'h12345678);
        drive_port(1, 1'b1, 1'b1, 16'h0000, 32'h0BADF00D);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b110) begin
            tests_failed++; $display("FAIL extremes_wr_gnt: got %b expected 110", gnt);
        end
        step(); idle_all();
        drive_port(0, 1'b1, 1'b0, 16'hFFFF, 32'h0);
        drive_port(1, 1'b1, 1'b0, 16'h0000, 32'h0);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b011) begin
            tests_failed++; $display("FAIL extremes_rd_gnt: got %b expected 011", gnt);
        end
        step(); idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b011 || rd_of(0) !== 32'h12345678 || rd_of(1) !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL extremes_rdata: got rvalid %b p0 %h p1 %h expected 011 12345678 0badf00d", rvalid, rd_of(0), rd_of(1));
        end
    endtask

`ifdef SRAM_ARB_BYTE_WRITE_EN
    task automatic test_byte_write();
        step(); idle_all();
        drive_port(0, 1'b1, 1'b1, 16'h0010, 32'hFFFFFFFF);
        @(negedge clk);
        step();
        drive_port(0, 1'b1, 1'b1, 16'h0010, 32'h00000000);
        be[0 +: BEW] = 4'b0101;
        @(negedge clk);
        step();
        drive_port(0, 1'b1, 1'b1, 16'h0010, 32'h12345678);
        be[0 +: BEW] = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b001) begin
            tests_failed++; $display("FAIL byte_be0_gnt: got %b expected 001", gnt);
        end
        step();
        drive_port(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        @(negedge clk);
        step(); idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b001 || rd_of(0) !== 32'hFF00FF00) begin
            tests_failed++; $display("FAIL byte_rdata: got rvalid %b rdata %h expected 001 ff00ff00", rvalid, rd_of(0));
        end
    endtask
`endif

    task automatic test_reset_midop();
        step(); idle_all();
        drive_port(1, 1'b1, 1'b0, 16'h0001, 32'h0);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b010) begin
            tests_failed++; $display("FAIL midrst_gnt: got %b expected 010", gnt);
        end
        #1;
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b000) begin
            tests_failed++; $display("FAIL midrst_rvalid: got %b expected 000", rvalid);
        end
        step();
        rst_n = 1'b1;
        drive_port(0, 1'b1, 1'b0, 16'h0001, 32'h0);
        drive_port(1, 1'b1, 1'b0, 16'h0005, 32'h0);
        drive_port(2, 1'b1, 1'b0, 16'h0009, 32'h0);
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b001 || rvalid !== 3'b000) begin
            tests_failed++; $display("FAIL midrst_first: got gnt %b rvalid %b expected 001 000", gnt, rvalid);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (gnt !== 3'b010 || rvalid !== 3'b001) begin
            tests_failed++; $display("FAIL midrst_second: got gnt %b rvalid %b expected 010 001", gnt, rvalid);
        end
        step(); idle_all();
        @(negedge clk);
        tests_run++;
        if (rvalid !== 3'b010) begin
            tests_failed++; $display("FAIL midrst_third_rvalid: got %b expected 010", rvalid);
        end
    endtask

    // Reference model: word-addressed memory, per-bank pointer, per-port read result.
    logic [DW-1:0] m_mem [int];
    int            m_ptr [NB];
    logic [NP-1:0] m_rvalid;
    logic [DW-1:0] m_rdata [NP];
    bit            m_rknown [NP];

    task automatic test_random();
        logic [NP-1:0] prev_req, prev_gnt, exp_g, nv;
        logic [AW-1:0] a;
        int            b, p;
        bit            done;
        rst_n = 1'b0;
        idle_all();
        step(); step();
        rst_n = 1'b1;
        m_mem.delete();
        for (int i = 0; i < NB; i++) m_ptr[i] = 0;
        m_rvalid = '0;
        for (int i = 0; i < NP; i++) begin m_rdata[i] = '0; m_rknown[i] = 1'b1; end
        prev_req = '0; prev_gnt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            for (int q = 0; q < NP; q++) begin
                if (!(prev_req[q] && !prev_gnt[q])) begin
                    a = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF0 + $urandom_range(0, 15)) : AW'($urandom_range(0, 15));
                    drive_port(q, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, DW'($urandom));
`ifdef SRAM_ARB_BYTE_WRITE_EN
                    be[q*BEW +: BEW] = ($urandom_range(0, 1) == 1) ? 4'hF : BEW'($urandom_range(0, 15));
`endif
                end
            end
            exp_g = '0;
            for (int bk = 0; bk < NB; bk++) begin
                done = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    p = (m_ptr[bk] + k) % NP;
                    if (!done && req[p] && (int'(addr[p*AW +: AW]) % NB) == bk) begin
                        exp_g[p] = 1'b1;
                        done = 1'b1;
                    end
                end
            end
            @(negedge clk);
            tests_run++;
            if (gnt !== exp_g) begin
                tests_failed++; $display("FAIL rand_gnt cyc %0d: got %b expected %b", cyc, gnt, exp_g);
            end
            tests_run++;
            if (rvalid !== m_rvalid) begin
                tests_failed++; $display("FAIL rand_rvalid cyc %0d: got %b expected %b", cyc, rvalid, m_rvalid);
            end
            for (int q = 0; q < NP; q++) begin
                if (m_rknown[q]) begin
                    tests_run++;
                    if (rd_of(q) !== m_rdata[q]) begin
                        tests_failed++; $display("FAIL rand_rdata cyc %0d port %0d: got %h expected %h", cyc, q, rd_of(q), m_rdata[q]);
                    end
                end
            end
            nv = '0;
            for (int q = 0; q < NP; q++) begin
                if (exp_g[q]) begin
                    a = addr[q*AW +: AW];
                    b = int'(a) % NB;
                    m_ptr[b] = (q + 1) % NP;
                    if (we[q]) begin
`ifdef SRAM_ARB_BYTE_WRITE_EN
                        if (be[q*BEW +: BEW] == 4'hF) m_mem[int'(a)] = wdata[q*DW +: DW];
                        else if (m_mem.exists(int'(a))) begin
                            for (int k = 0; k < BEW; k++)
                                if (be[q*BEW + k]) m_mem[int'(a)][k*8 +: 8] = wdata[q*DW + k*8 +: 8];
                        end
`else
                        m_mem[int'(a)] = wdata[q*DW +: DW];
`endif
                    end else begin
                        nv[q] = 1'b1;
                        m_rknown[q] = m_mem.exists(int'(a));
                        if (m_rknown[q]) m_rdata[q] = m_mem[int'(a)];
                    end
                end
            end
            m_rvalid = nv;
            prev_req = req;
            prev_gnt = gnt;
        end
        step(); idle_all();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        test_reset();
        test_write_read();
        test_contention();
        test_parallel_banks();
        test_extremes();
`ifdef SRAM_ARB_BYTE_WRITE_EN
        test_byte_write();
`endif
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
